riscv_multicycle_core: RTL

- Parametrised multi-cycle RV-subset core, the successor to the single-cycle processor.
- Each instruction steps through an FSM (FETCH/DECODE/EXEC/MEM/WB), so one ALU and a registered datapath serve every stage.
- Instruction and data memories sit outside the core behind req/ready handshake ports, which allows wait-stated memories.
- Register file and ALU are internal. Instruction set matches the existing datapath (add, sub, and, or, addi, ld, sd, beq, blt) with XLEN/NREGS generalised.

---
 rtl/riscv_multicycle_core.sv | 138 +++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core: multi-cycle RV subset core (add/sub/and/or/addi/ld/sd/beq/blt), FETCH/DECODE/EXEC/MEM/WB FSM.
// Optional CORE_PERF_CNT_EN macro builds cycle/instret counters; otherwise those ports read 0.
module riscv_multicycle_core #(
    parameter int XLEN = 64,
    parameter int NREGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            halted,
    output logic [2:0]      state,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt
);
    localparam int RW = $clog2(NREGS);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7} state_t;
    state_t st;
    logic [31:0] ir;
    logic [XLEN-1:0] pc_r, a, b, imm, alu_out, mdr, alu, imm_dec;
    logic [XLEN-1:0] rf [NREGS];
    logic halted_r;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [RW-1:0] rs1, rs2, rd;
    logic is_r, is_add, is_sub, is_and, is_or, is_addi, is_ld, is_sd, is_beq, is_blt, is_br, legal, taken;
    // Instruction field decode from the latched IR; IR is stable from DECODE through WB.
    always_comb begin
        op = ir[6:0];
        f3 = ir[14:12];
        f7 = ir[31:25];
        rd = ir[7 +: RW];
        rs1 = ir[15 +: RW];
        rs2 = ir[20 +: RW];
        is_r = op == 7'h33;
        is_add = is_r && f3 == 3'd0 && f7 == 7'h00;
        is_sub = is_r && f3 == 3'd0 && f7 == 7'h20;
        is_and = is_r && f3 == 3'd7 && f7 == 7'h00;
        is_or = is_r && f3 == 3'd6 && f7 == 7'h00;
        is_addi = op == 7'h13 && f3 == 3'd0;
        is_ld = op == 7'h03 && f3 == 3'd3;
        is_sd = op == 7'h23 && f3 == 3'd3;
        is_beq = op == 7'h63 && f3 == 3'd0;
        is_blt = op == 7'h63 && f3 == 3'd4;
        is_br = is_beq || is_blt;
        legal = is_add || is_sub || is_and || is_or || is_addi || is_ld || is_sd || is_br;
        imm_dec = is_sd ? {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]}
                : is_br ? {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}
                : {{(XLEN-12){ir[31]}}, ir[31:20]};
        alu = is_sub ? a - b : is_and ? a & b : is_or ? a | b : a + (is_r ? b : imm);
        taken = (is_beq && a == b) || (is_blt && $signed(a) < $signed(b));
    end
    // Handshake requests gate on reset so they drop the instant reset asserts; retire marks the completing cycle.
    assign imem_req = st == FETCH && reset;
    assign imem_addr = pc_r;
    assign dmem_req = st == MEM;
    assign dmem_we = is_sd;
    assign dmem_addr = alu_out;
    assign dmem_wdata = b;
    assign pc = pc_r;
    assign state = st;
    assign halted = halted_r;
    assign retire = st == WB || (st == EXEC && is_br) || (st == MEM && is_sd && dmem_ready);
    // Main FSM and registered datapath; one ALU shared across stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= FETCH;
            pc_r <= RESET_PC;
            ir <= '0;
            a <= '0;
            b <= '0;
            imm <= '0;
            alu_out <= '0;
            mdr <= '0;
            halted_r <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            case (st)
                FETCH: if (imem_ready) begin
                    ir <= imem_rdata;
                    st <= DECODE;
                end
                DECODE: begin
                    a <= rf[rs1];
                    b <= rf[rs2];
                    imm <= imm_dec;
                    st <= legal ? EXEC : HALT;
                    halted_r <= !legal;
                end
                EXEC: begin
                    alu_out <= alu;
                    if (is_br) begin
                        pc_r <= pc_r + (taken ? imm : FOUR);
                        st <= FETCH;
                    end else st <= (is_ld || is_sd) ? MEM : WB;
                end
                MEM: if (dmem_ready) begin
                    mdr <= dmem_rdata;
                    if (is_sd) pc_r <= pc_r + FOUR;
                    st <= is_sd ? FETCH : WB;
                end
                WB: begin
                    if (|rd) rf[rd] <= is_ld ? mdr : alu_out;
                    pc_r <= pc_r + FOUR;
                    st <= FETCH;
                end
                default: st <= HALT;
            endcase
        end
    end
`ifdef CORE_PERF_CNT_EN
    // Performance counters; both freeze once the core halts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instret_cnt <= '0;
        end else if (!halted_r) begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (retire) instret_cnt <= instret_cnt + 1'b1;
        end
    end
`else
    assign cycle_cnt = '0;
    assign instret_cnt = '0;
`endif
endmodule
